// File: rtl/dct8_rot_sched.sv
// dct8_rot_sched: shares one DCT8 rotator across the three odd-part rotations.
// Optional completed-block counter on blk_count when DCT8_SCHED_CNT_EN is defined.
module dct8_rot_sched #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x0,
    input  logic [DATA_W-1:0] in_y0,
    input  logic [DATA_W-1:0] in_x1,
    input  logic [DATA_W-1:0] in_y1,
    input  logic [DATA_W-1:0] in_x2,
    input  logic [DATA_W-1:0] in_y2,
    output logic [DATA_W-1:0] rot_x,
    output logic [DATA_W-1:0] rot_y,
    output logic [1:0]        rot_angle,
    input  logic [DATA_W-1:0] rot_xo,
    input  logic [DATA_W-1:0] rot_yo,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_x0,
    output logic [DATA_W-1:0] out_y0,
    output logic [DATA_W-1:0] out_x1,
    output logic [DATA_W-1:0] out_y1,
    output logic [DATA_W-1:0] out_x2,
    output logic [DATA_W-1:0] out_y2
`ifdef DCT8_SCHED_CNT_EN
    ,
    output logic [15:0]       blk_count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        ROT0,
        ROT1,
        ROT2,
        DONE
    } state_t;

    localparam logic [1:0] ANG_PI16  = 2'b00;
    localparam logic [1:0] ANG_3PI16 = 2'b10;
    localparam logic [1:0] ANG_PI8   = 2'b01;

    state_t state_q, state_d;

    logic [DATA_W-1:0] opx_q  [3];
    logic [DATA_W-1:0] opy_q  [3];
    logic [DATA_W-1:0] opx_d  [3];
    logic [DATA_W-1:0] opy_d  [3];
    logic [DATA_W-1:0] resx_q [3];
    logic [DATA_W-1:0] resy_q [3];
    logic [DATA_W-1:0] resx_d [3];
    logic [DATA_W-1:0] resy_d [3];

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rot_x     = '0;
        rot_y     = '0;
        rot_angle = ANG_PI16;
        opx_d     = opx_q;
        opy_d     = opy_q;
        resx_d    = resx_q;
        resy_d    = resy_q;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opx_d[0] = in_x0;
                    opy_d[0] = in_y0;
                    opx_d[1] = in_x1;
                    opy_d[1] = in_y1;
                    opx_d[2] = in_x2;
                    opy_d[2] = in_y2;
                    state_d  = ROT0;
                end
            end
            ROT0: begin
                rot_x     = opx_q[0];
                rot_y     = opy_q[0];
                rot_angle = ANG_PI16;
                resx_d[0] = rot_xo;
                resy_d[0] = rot_yo;
                state_d   = ROT1;
            end
            ROT1: begin
                rot_x     = opx_q[1];
                rot_y     = opy_q[1];
                rot_angle = ANG_3PI16;
                resx_d[1] = rot_xo;
                resy_d[1] = rot_yo;
                state_d   = ROT2;
            end
            ROT2: begin
                rot_x     = opx_q[2];
                rot_y     = opy_q[2];
                rot_angle = ANG_PI8;
                resx_d[2] = rot_xo;
                resy_d[2] = rot_yo;
                state_d   = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < 3; i++) begin
                opx_q[i]  <= '0;
                opy_q[i]  <= '0;
                resx_q[i] <= '0;
                resy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 3; i++) begin
                opx_q[i]  <= opx_d[i];
                opy_q[i]  <= opy_d[i];
                resx_q[i] <= resx_d[i];
                resy_q[i] <= resy_d[i];
            end
        end
    end

    assign out_x0 = resx_q[0];
    assign out_y0 = resy_q[0];
    assign out_x1 = resx_q[1];
    assign out_y1 = resy_q[1];
    assign out_x2 = resx_q[2];
    assign out_y2 = resy_q[2];

`ifdef DCT8_SCHED_CNT_EN
    logic        out_hs;
    logic [15:0] cnt_q, cnt_d;

    assign out_hs = (state_q == DONE) && out_ready;

    // Saturating: a wrapped count would look like a fresh start downstream.
    always_comb begin
        cnt_d = cnt_q;
        if (out_hs && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_dct8_rot_sched.sv
// Bench for dct8_rot_sched with a behavioural Q1.15 rotator and result scoreboard.
module tb_dct8_rot_sched;

    typedef struct packed {
        logic [15:0] x0;
        logic [15:0] y0;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
    } blk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x0 = '0, in_y0 = '0, in_x1 = '0;
    logic [15:0] in_y1 = '0, in_x2 = '0, in_y2 = '0;
    logic [15:0] rot_x, rot_y, rot_xo, rot_yo;
    logic [1:0]  rot_angle;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_x0, out_y0, out_x1, out_y1, out_x2, out_y2;
`ifdef DCT8_SCHED_CNT_EN
    logic [15:0] blk_count;
`endif
    logic [31:0] rot_res;

    int   tests = 0;
    int   fails = 0;
    blk_t sb[$];

    always #5 clk = ~clk;

    dct8_rot_sched #(.DATA_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x0    (in_x0),
        .in_y0    (in_y0),
        .in_x1    (in_x1),
        .in_y1    (in_y1),
        .in_x2    (in_x2),
        .in_y2    (in_y2),
        .rot_x    (rot_x),
        .rot_y    (rot_y),
        .rot_angle(rot_angle),
        .rot_xo   (rot_xo),
        .rot_yo   (rot_yo),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x0   (out_x0),
        .out_y0   (out_y0),
        .out_x1   (out_x1),
        .out_y1   (out_y1),
        .out_x2   (out_x2),
        .out_y2   (out_y2)
`ifdef DCT8_SCHED_CNT_EN
        ,
        .blk_count(blk_count)
`endif
    );

    function automatic logic [31:0] rot_fn(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic [1:0]  a);
        int c, s, sx, sy, xo, yo;
        case (a)
            2'b00:   begin c = 32138; s = 6393;  end
            2'b10:   begin c = 27246; s = 18205; end
            2'b01:   begin c = 30274; s = 12540; end
            default: begin c = 0;     s = 0;     end
        endcase
        sx = int'($signed(x));
        sy = int'($signed(y));
        xo = (sx * c - sy * s) >>> 15;
        yo = (sx * s + sy * c) >>> 15;
        return {xo[15:0], yo[15:0]};
    endfunction

    function automatic blk_t model(input blk_t b);
        blk_t        r;
        logic [31:0] t;
        t = rot_fn(b.x0, b.y0, 2'b00);
        r.x0 = t[31:16];
        r.y0 = t[15:0];
        t = rot_fn(b.x1, b.y1, 2'b10);
        r.x1 = t[31:16];
        r.y1 = t[15:0];
        t = rot_fn(b.x2, b.y2, 2'b01);
        r.x2 = t[31:16];
        r.y2 = t[15:0];
        return r;
    endfunction

    always_comb rot_res = rot_fn(rot_x, rot_y, rot_angle);
    assign rot_xo = rot_res[31:16];
    assign rot_yo = rot_res[15:0];

    function automatic blk_t outs();
        return {out_x0, out_y0, out_x1, out_y1, out_x2, out_y2};
    endfunction

    function automatic blk_t rnd_blk();
        blk_t b;
        b = {16'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 16'($urandom)};
        return b;
    endfunction

    task automatic set_ops(input blk_t b);
        in_x0 = b.x0;
        in_y0 = b.y0;
        in_x1 = b.x1;
        in_y1 = b.y1;
        in_x2 = b.x2;
        in_y2 = b.y2;
    endtask

    task automatic send_block(input blk_t b, output blk_t r, output bit to);
        int k;
        to = 1'b0;
        @(negedge clk);
        set_ops(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) to = 1'b1;
        else sb.push_back(model(b));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) to = 1'b1;
        r = outs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs got rdy=%b vld=%b exp rdy=1 vld=0",
                     in_ready, out_valid);
        end
        tests++;
        if (outs() !== '0) begin
            fails++;
            $display("FAIL reset_outs got=%h exp=0", outs());
        end
        tests++;
        if (rot_x !== 16'd0 || rot_y !== 16'd0 || rot_angle !== 2'b00) begin
            fails++;
            $display("FAIL reset_rot got x=%h y=%h a=%b exp 0",
                     rot_x, rot_y, rot_angle);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset got rdy=%b vld=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        blk_t b, exp, gold;
        b    = {16'd16384, 16'd0, 16'd8192, 16'd8192, 16'd0, 16'd16384};
        gold = {16'd16069, 16'd3196, 16'd2260, 16'd11362,
                16'hE782, 16'd15137};
        @(negedge clk);
        set_ops(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_rdy got=%b exp=1", in_ready);
        end
        sb.push_back(model(b));
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (rot_angle !== 2'b00 || rot_x !== 16'd16384 || rot_y !== 16'd0) begin
            fails++;
            $display("FAIL rot0 got a=%b x=%h y=%h exp 00/4000/0000",
                     rot_angle, rot_x, rot_y);
        end
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rot0_hs got rdy=%b vld=%b exp 0/0",
                     in_ready, out_valid);
        end
        @(negedge clk);
        tests++;
        if (rot_angle !== 2'b10 || rot_x !== 16'd8192 || rot_y !== 16'd8192) begin
            fails++;
            $display("FAIL rot1 got a=%b x=%h y=%h exp 10/2000/2000",
                     rot_angle, rot_x, rot_y);
        end
        @(negedge clk);
        tests++;
        if (rot_angle !== 2'b01 || rot_x !== 16'd0 || rot_y !== 16'd16384) begin
            fails++;
            $display("FAIL rot2 got a=%b x=%h y=%h exp 01/0000/4000",
                     rot_angle, rot_x, rot_y);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_valid got=%b exp=0", out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency got vld=%b exp=1 at accept+4", out_valid);
        end
        tests++;
        if (outs() !== gold) begin
            fails++;
            $display("FAIL single_gold got=%h exp=%h", outs(), gold);
        end
        exp = sb.pop_front();
        tests++;
        if (outs() !== exp) begin
            fails++;
            $display("FAIL single_sb got=%h exp=%h", outs(), exp);
        end
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rot_x !== 16'd0) begin
            fails++;
            $display("FAIL single_ret got rdy=%b vld=%b rx=%h exp 1/0/0",
                     in_ready, out_valid, rot_x);
        end
    endtask

    task automatic test_backpressure();
        blk_t b, exp;
        int   k;
        b = rnd_blk();
        @(negedge clk);
        set_ops(b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        sb.push_back(model(b));
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL bp_timeout got vld=0 exp=1");
        end
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (outs() !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d] got=%h vld=%b rdy=%b exp=%h 1/0",
                         i, outs(), out_valid, in_ready, exp);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release got rdy=%b vld=%b exp 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        blk_t blks [4];
        blk_t exp;
        int   sent, rcv, last;
        for (int i = 0; i < 4; i++) blks[i] = rnd_blk();
        sent = 0;
        rcv  = 0;
        last = 0;
        @(posedge clk);
        #1;
        set_ops(blks[0]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && rcv < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra got vld=1 exp no output");
                end else begin
                    exp = sb.pop_front();
                    if (outs() !== exp) begin
                        fails++;
                        $display("FAIL b2b_data[%0d] got=%h exp=%h",
                                 rcv, outs(), exp);
                    end
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(blks[sent]));
                if (sent > 0) begin
                    tests++;
                    if (c - last != 5) begin
                        fails++;
                        $display("FAIL b2b_period got=%0d exp=5", c - last);
                    end
                end
                last = c;
                sent++;
                @(posedge clk);
                #1;
                if (sent < 4) set_ops(blks[sent]);
                else in_valid = 1'b0;
            end
        end
        tests++;
        if (sent != 4 || rcv != 4 || sb.size() != 0) begin
            fails++;
            $display("FAIL b2b_count got sent=%0d rcv=%0d left=%0d exp 4/4/0",
                     sent, rcv, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        blk_t b, r, gold, exp;
        bit   to;
        b    = {16'd16384, 16'd0, 16'd8192, 16'd8192, 16'd0, 16'd16384};
        gold = {16'd16069, 16'd3196, 16'd2260, 16'd11362,
                16'hE782, 16'd15137};
        @(posedge clk);
        #1;
        set_ops(b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mr_idle got rdy=%b exp=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (rot_angle !== 2'b10 || out_x0 !== 16'd16069) begin
            fails++;
            $display("FAIL mr_rot1 got a=%b x0=%h exp 10/3EC5",
                     rot_angle, out_x0);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (outs() !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL mr_clear got=%h vld=%b rdy=%b exp 0/0/1",
                     outs(), out_valid, in_ready);
        end
        tests++;
        if (rot_x !== 16'd0 || rot_y !== 16'd0 || rot_angle !== 2'b00) begin
            fails++;
            $display("FAIL mr_rot_clear got x=%h y=%h a=%b exp 0",
                     rot_x, rot_y, rot_angle);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send_block(b, r, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL mr_timeout got timeout exp completion");
        end
        tests++;
        if (r !== gold) begin
            fails++;
            $display("FAIL mr_after got=%h exp=%h", r, gold);
        end
        if (sb.size() > 0) exp = sb.pop_front();
    endtask

`ifdef DCT8_SCHED_CNT_EN
    task automatic test_counter();
        blk_t b, r, exp;
        bit   to;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (blk_count !== 16'd0) begin
            fails++;
            $display("FAIL cnt_reset got=%h exp=0", blk_count);
        end
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            b = rnd_blk();
            send_block(b, r, to);
            tests++;
            if (to || sb.size() == 0) begin
                fails++;
                $display("FAIL cnt_blk_timeout[%0d] got timeout exp done", i);
            end else begin
                exp = sb.pop_front();
                if (r !== exp) begin
                    fails++;
                    $display("FAIL cnt_blk[%0d] got=%h exp=%h", i, r, exp);
                end
            end
        end
        tests++;
        if (blk_count !== 16'd3) begin
            fails++;
            $display("FAIL cnt_three got=%h exp=3", blk_count);
        end
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        #1 release dut.cnt_q;
        tests++;
        if (blk_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL cnt_preload got=%h exp=FFFF", blk_count);
        end
        send_block(rnd_blk(), r, to);
        if (sb.size() > 0) exp = sb.pop_front();
        tests++;
        if (to || blk_count !== 16'hFFFF) begin
            fails++;
            $display("FAIL cnt_sat got=%h to=%b exp=FFFF", blk_count, to);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
`ifdef DCT8_SCHED_CNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dct8_rot_sched.md
# dct8_rot_sched

Sequencer that time-shares one combinational DCT8 rotator (x/y/angle_sel in, rotated x/y out) across the three fixed-angle rotations of an 8-point DCT odd-part stage. It accepts three operand pairs per block over a valid/ready handshake and drives the rotator for one cycle per pair. It captures each rotated result and presents all three result pairs together over a second valid/ready handshake. The block sits between the butterfly stage and the output stage of the DCT8 datapath; the rotator is instantiated outside it.

## Interface
- DATA_W, 16, operand/result width (two's complement), equal to the rotator DATA_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand block valid
- in_ready  out  1  block can accept operands
- in_x0/in_y0, in_x1/in_y1, in_x2/in_y2  in  DATA_W each  operand pairs 0..2
- rot_x, rot_y  out  DATA_W each  rotator operand inputs
- rot_angle  out  2  rotator angle_sel
- rot_xo, rot_yo  in  DATA_W each  rotator results (combinational from rot_x/rot_y/rot_angle)
- out_valid  out  1  result block valid
- out_ready  in  1  downstream accepts results
- out_x0/out_y0, out_x1/out_y1, out_x2/out_y2  out  DATA_W each  rotated pairs 0..2
- blk_count  out  16  completed-block counter (only with DCT8_SCHED_CNT_EN)

## Operation
- Angle mapping, fixed: pair0 -> 2'b00 (pi/16), pair1 -> 2'b10 (3pi/16), pair2 -> 2'b01 (pi/8). Code 2'b11 is never driven.
- FSM states: IDLE, ROT0, ROT1, ROT2, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, register all six operands and go to ROT0.
- ROT0/ROT1/ROT2: drive rot_x/rot_y with the registered pair 0/1/2 and rot_angle with its code. On the clock edge ending the state, capture rot_xo/rot_yo into out_xN/out_yN, then advance ROT0->ROT1->ROT2->DONE unconditionally.
- DONE: out_valid=1. Result registers are held stable. When out_ready, return to IDLE.
- Outside the ROT states, rot_x=rot_y=0 and rot_angle=2'b00.
- No arithmetic in this block: results are copied bit-exact from the rotator, with no rounding, saturation or width change.
- in_ready is 0 in every state except IDLE. An operand block is never accepted while a block is in flight or awaiting output.
- Operand registers update only on an input handshake. Result registers update only in the ROT states.

## Timing
- Reset (asynchronous, any state, including mid-rotation): state=IDLE, in_ready=1, out_valid=0, every out_x*/out_y*=0, rot_x=rot_y=0, rot_angle=0, blk_count=0. An in-flight block is discarded.
- Input handshake on edge E: ROT0 is active in cycle E+1, ROT1 in E+2, ROT2 in E+3, and out_valid rises in cycle E+4. Latency from accept to out_valid is 4 cycles.
- Output handshake on edge F: in_ready=1 in cycle F+1. Minimum block period is 5 cycles.
- in_valid asserted together with out_ready in DONE: the input is not accepted in that cycle; it is accepted in the IDLE cycle that follows.
- out_ready held low: DONE persists indefinitely and outputs stay stable.
- in_valid/operands may change freely when in_ready=0; they are ignored.

## Configuration
- Macro: DCT8_SCHED_CNT_EN.
- Defined: blk_count port exists. It increments by 1 on each output handshake, saturates at 16'hFFFF, and resets to 0.
- Undefined: no blk_count port and no counter logic; all other behaviour is identical.

## Test plan
The bench instantiates a behavioural rotator: Q1.15 coefficients 32138/6393, 30274/12540, 27246/18205, arithmetic shift right by 15.
- Reset and idle: rst_n low then high -> in_ready=1, out_valid=0, all outputs 0, rot_angle=0.
- Single block: pair0=(16384,0), pair1=(8192,8192), pair2=(0,16384), out_ready=1 -> out_valid 4 cycles after accept. Results: (16069,3196), (2260,11362), (-6270,15137). rot_angle sequence is 00,10,01.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> results stable, in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle.
- Back-to-back: in_valid held high, out_ready=1, 4 distinct blocks -> accepts every 5 cycles, results in order, no operand block lost.
- Mid-operation reset: assert rst_n low during ROT1 -> outputs clear immediately. After release, the next block produces correct results.
- With DCT8_SCHED_CNT_EN: 3 completed blocks -> blk_count=3. Preload the counter to 16'hFFFF via force, complete 1 block -> blk_count stays 16'hFFFF.
